scr1_tb_imem_match_mon: RTL and testbench

Parametrised instruction-fetch match monitor for the SCR1 AHB testbench. Watches the core's imem response channel, compares every valid fetched word against NUM_CH independent masked patterns, counts hits per channel, and queues a record {channel, PC, instruction} per hit in a FIFO drained over a valid/ready port. Instantiated beside scr1_top_tb_ahb; hierarchical probes of imem_resp, imem_rdata and curr_pc are bound to its ports by the bench.

---
 rtl/scr1_tb_mon_pkg.sv | 26 ++
 rtl/scr1_tb_mon_fifo.sv | 54 +++++
 rtl/scr1_tb_imem_match_mon.sv | 118 +++++++++++
 tb/tb_scr1_tb_imem_match_mon.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_tb_mon_pkg.sv
// Shared definitions for the SCR1 imem match monitor: response codes,
// default record layout and the channel-index width helper.
package scr1_tb_mon_pkg;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_ERR  = 2'b10,
    RESP_RSV  = 2'b11
  } imem_resp_e;

  localparam int unsigned MON_CH_W   = 2;
  localparam int unsigned MON_PC_W   = 32;
  localparam int unsigned MON_DATA_W = 32;

  typedef struct packed {
    logic [MON_CH_W-1:0]   ch;
    logic [MON_PC_W-1:0]   pc;
    logic [MON_DATA_W-1:0] data;
  } mon_rec_t;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scr1_tb_mon_fifo.sv
// Single-clock record FIFO; no bypass, so a push into an empty FIFO is
// visible on the output only after the write edge.
module scr1_tb_mon_fifo
  import scr1_tb_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == FULL_CNT);
    empty   = (cnt_q == '0);
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    dout    = empty ? '0 : mem[rd_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/scr1_tb_imem_match_mon.sv
// Instruction-fetch match monitor: masked pattern match per channel, hit
// counters, one-shot arming, and a lowest-index-wins record FIFO.
module scr1_tb_imem_match_mon
  import scr1_tb_mon_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16,
  parameter bit          LOG_EN     = 1'b1,
  localparam int unsigned CH_W      = ch_idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               imem_resp,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic [PC_W-1:0]          curr_pc,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_oneshot,
  input  logic [NUM_CH*DATA_W-1:0] ch_pat,
  input  logic [NUM_CH*DATA_W-1:0] ch_mask,
  input  logic [NUM_CH-1:0]        ch_rearm,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CH_W-1:0]          rec_ch,
  output logic [PC_W-1:0]          rec_pc,
  output logic [DATA_W-1:0]        rec_data,
  output logic [NUM_CH*CNT_W-1:0]  hit_cnt,
  output logic                     ovf,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned REC_W = CH_W + PC_W + DATA_W;

  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] armed_q, armed_d;
  logic [CNT_W-1:0]  hit_q [NUM_CH];
  logic [CNT_W-1:0]  hit_d [NUM_CH];
  logic [CH_W-1:0]   win_ch;
  logic              qual, push, pop, drop, full, empty;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [REC_W-1:0]  rec_dout;

  always_comb begin
    qual    = (imem_resp == RESP_OK);
    match   = '0;
    armed_d = armed_q;
    win_ch  = '0;
    push    = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      match[c] = qual && ch_en[c] && armed_q[c] &&
                 (((imem_rdata ^ ch_pat[c*DATA_W +: DATA_W]) & ch_mask[c*DATA_W +: DATA_W]) == '0);
      // rearm dominates a same-cycle one-shot disarm
      armed_d[c] = ch_rearm[c] | (armed_q[c] & ~(match[c] & ch_oneshot[c]));
      hit_d[c]   = (match[c] && (hit_q[c] != '1)) ? hit_q[c] + CNT_W'(1) : hit_q[c];
      if (match[c] && !push) begin
        push   = 1'b1;
        win_ch = CH_W'(c);
      end
    end
  end

  always_comb begin
    rec_valid = !empty;
    pop       = rec_valid && rec_ready;
    drop      = push && full && !pop;
    ovf_d     = ovf_q | drop;
    drop_d    = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= '1;
      hit_q   <= '{default: '0};
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      armed_q <= armed_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  scr1_tb_mon_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({win_ch, curr_pc, imem_rdata}),
    .pop   (pop),
    .dout  (rec_dout),
    .full  (full),
    .empty (empty)
  );

  assign {rec_ch, rec_pc, rec_data} = rec_dout;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

  always_comb begin
    hit_cnt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) hit_cnt[c*CNT_W +: CNT_W] = hit_q[c];
  end

`ifndef SYNTHESIS
  if (LOG_EN) begin : g_log
    always_ff @(posedge clk) begin
      if (!rst && push) $display("CH%0d PC: %h", win_ch, curr_pc);
    end
  end
`endif

endmodule

// File: tb/tb_scr1_tb_imem_match_mon.sv
// Directed bench for scr1_tb_imem_match_mon with hand-computed expectations.
module tb_scr1_tb_imem_match_mon;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   imem_resp;
  logic [31:0]  imem_rdata;
  logic [31:0]  curr_pc;
  logic [3:0]   ch_en, ch_oneshot, ch_rearm;
  logic [127:0] ch_pat, ch_mask;
  logic         rec_valid, rec_ready;
  logic [1:0]   rec_ch;
  logic [31:0]  rec_pc, rec_data;
  logic [63:0]  hit_cnt;
  logic         ovf;
  logic [15:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scr1_tb_imem_match_mon #(
    .NUM_CH     (4),
    .DATA_W     (32),
    .PC_W       (32),
    .FIFO_DEPTH (8),
    .CNT_W      (16),
    .LOG_EN     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_resp  (imem_resp),
    .imem_rdata (imem_rdata),
    .curr_pc    (curr_pc),
    .ch_en      (ch_en),
    .ch_oneshot (ch_oneshot),
    .ch_pat     (ch_pat),
    .ch_mask    (ch_mask),
    .ch_rearm   (ch_rearm),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_ch     (rec_ch),
    .rec_pc     (rec_pc),
    .rec_data   (rec_data),
    .hit_cnt    (hit_cnt),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hc(input int c);
    return hit_cnt[c*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    ch_en = '0; ch_oneshot = '0; ch_rearm = '0; ch_pat = '0; ch_mask = '0;
  endtask

  task automatic set_ch(input int c, input logic os, input logic [31:0] pat, input logic [31:0] mask);
    ch_en[c] = 1'b1;
    ch_oneshot[c] = os;
    ch_pat[c*32 +: 32] = pat;
    ch_mask[c*32 +: 32] = mask;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    imem_resp = 2'b01; curr_pc = pc; imem_rdata = data;
    step();
    imem_resp = 2'b00;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] pc, input logic [31:0] data);
    chk({tag, "_valid"}, 64'(rec_valid), 64'd1);
    chk({tag, "_pc"}, 64'(rec_pc), 64'(pc));
    chk({tag, "_data"}, 64'(rec_data), 64'(data));
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_resp = 2'b00; imem_rdata = '0; curr_pc = '0; rec_ready = 1'b0;
    clear_cfg();
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_ch", 64'(rec_ch), 64'd0);
    chk("rst_pc", 64'(rec_pc), 64'd0);
    chk("rst_data", 64'(rec_data), 64'd0);
    chk("rst_hits", hit_cnt, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // Exact match, then non-OK response codes are ignored
    set_ch(0, 1'b0, 32'h057E4505, 32'hFFFFFFFF);
    fetch(32'h200, 32'h057E4505);
    chk("t1_valid", 64'(rec_valid), 64'd1);
    chk("t1_ch", 64'(rec_ch), 64'd0);
    chk("t1_pc", 64'(rec_pc), 64'h200);
    chk("t1_data", 64'(rec_data), 64'h057E4505);
    chk("t1_hit0", 64'(hc(0)), 64'd1);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    chk("t1_empty", 64'(rec_valid), 64'd0);
    for (int r = 0; r < 4; r++) begin
      if (r == 1) continue;
      imem_resp = 2'(r); imem_rdata = 32'h057E4505; curr_pc = 32'h204;
      step();
      imem_resp = 2'b00;
      chk("t1_noqual_valid", 64'(rec_valid), 64'd0);
      chk("t1_noqual_hit0", 64'(hc(0)), 64'd1);
    end

    // Two channels match: lowest index wins, both count
    do_reset();
    clear_cfg();
    set_ch(0, 1'b0, 32'h00000013, 32'hFFFFFFFF);
    set_ch(2, 1'b0, 32'h00000013, 32'h0000007F);
    fetch(32'h300, 32'h00000013);
    chk("t2_ch", 64'(rec_ch), 64'd0);
    chk("t2_pc", 64'(rec_pc), 64'h300);
    chk("t2_hit0", 64'(hc(0)), 64'd1);
    chk("t2_hit2", 64'(hc(2)), 64'd1);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    chk("t2_single_rec", 64'(rec_valid), 64'd0);
    fetch(32'h304, 32'hABCDE093);
    chk("t2_mask_ch", 64'(rec_ch), 64'd2);
    chk("t2_mask_data", 64'(rec_data), 64'hABCDE093);
    chk("t2_mask_hit2", 64'(hc(2)), 64'd2);
    chk("t2_mask_hit0", 64'(hc(0)), 64'd1);

    // One-shot behaviour and rearm
    do_reset();
    clear_cfg();
    set_ch(1, 1'b1, 32'h00100073, 32'hFFFFFFFF);
    fetch(32'h400, 32'h00100073);
    fetch(32'h404, 32'h00100073);
    fetch(32'h408, 32'h00100073);
    chk("t3_hit1", 64'(hc(1)), 64'd1);
    chk("t3_ch", 64'(rec_ch), 64'd1);
    pop_expect("t3_first", 32'h400, 32'h00100073);
    chk("t3_one_rec", 64'(rec_valid), 64'd0);
    ch_rearm[1] = 1'b1;
    step();
    ch_rearm[1] = 1'b0;
    fetch(32'h500, 32'h00100073);
    chk("t3_rearm_hit1", 64'(hc(1)), 64'd2);
    ch_rearm[1] = 1'b1;
    step();
    fetch(32'h600, 32'h00100073);
    ch_rearm[1] = 1'b0;
    fetch(32'h604, 32'h00100073);
    fetch(32'h608, 32'h00100073);
    chk("t3_hits_final", 64'(hc(1)), 64'd4);
    pop_expect("t3_r500", 32'h500, 32'h00100073);
    pop_expect("t3_r600", 32'h600, 32'h00100073);
    pop_expect("t3_r604", 32'h604, 32'h00100073);
    chk("t3_drained", 64'(rec_valid), 64'd0);

    // Overflow, then push into a full FIFO while popping
    do_reset();
    clear_cfg();
    set_ch(0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) fetch(32'h1000 + 32'(4*i), 32'(i));
    chk("t4_full_ovf", 64'(ovf), 64'd0);
    chk("t4_full_drop", 64'(drop_cnt), 64'd0);
    for (int i = 8; i < 11; i++) fetch(32'h1000 + 32'(4*i), 32'(i));
    chk("t4_ovf", 64'(ovf), 64'd1);
    chk("t4_drop", 64'(drop_cnt), 64'd3);
    chk("t4_hit0", 64'(hc(0)), 64'd11);
    chk("t4_head", 64'(rec_pc), 64'h1000);
    rec_ready = 1'b1;
    fetch(32'h2000, 32'h99);
    rec_ready = 1'b0;
    chk("t5_drop", 64'(drop_cnt), 64'd3);
    for (int i = 1; i < 8; i++) pop_expect("t5_drain", 32'h1000 + 32'(4*i), 32'(i));
    pop_expect("t5_last", 32'h2000, 32'h99);
    chk("t5_empty", 64'(rec_valid), 64'd0);
    chk("t5_ovf_sticky", 64'(ovf), 64'd1);

    // Reset with queued records has priority over a same-cycle push
    for (int i = 0; i < 3; i++) fetch(32'h3000 + 32'(4*i), 32'hA0 + 32'(i));
    chk("t6_pre_valid", 64'(rec_valid), 64'd1);
    chk("t6_pre_hit0", 64'(hc(0)), 64'd15);
    rst = 1'b1;
    imem_resp = 2'b01; curr_pc = 32'h4000; imem_rdata = 32'h1;
    step();
    rst = 1'b0;
    imem_resp = 2'b00;
    chk("t6_valid", 64'(rec_valid), 64'd0);
    chk("t6_hits", hit_cnt, 64'd0);
    chk("t6_ovf", 64'(ovf), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_pc", 64'(rec_pc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
